// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS core front end.
//   - instruction field bit positions
//   - fetch FSM state encoding (S_FETCH / S_HOLD / S_DROP)
//   - default reset PC
//   - PC helper functions (word alignment, +4 with modulo-2^32 wrap)
package mips_pkg;

  // Instruction field bit positions
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_FETCH = 2'b00,  // request outstanding at pc
    S_HOLD  = 2'b01,  // fetched word parked while the pipeline is stalled
    S_DROP  = 2'b10   // request outstanding for a stale address; data is discarded
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Next sequential PC; wraps naturally modulo 2^32.
  function automatic logic [31:0] pc_inc4(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Per-cycle priority: flush (kill valid, keep fields) > stall (hold) >
// load (capture new instruction) > bubble (clear valid, keep fields).
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   flush, stall      - hazard controls
//   load              - a new instruction is available this cycle
//   new_instr/new_pc4 - instruction word and its fetch PC + 4
//   id_valid/id_instr/id_pc4 - registered IF/ID contents
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc4,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4
);

  // IF/ID register update with flush/stall/load priority
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= 32'h0000_0000;
      id_pc4   <= 32'h0000_0000;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (stall) begin
      id_valid <= id_valid;
    end else if (load) begin
      id_valid <= 1'b1;
      id_instr <= new_instr;
      id_pc4   <= new_pc4;
    end else begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: instruction fetch + IF/ID register for the MIPS core.
// Keeps the PC, issues word fetches over a req/ack handshake, and presents
// the latched instruction with its PC+4 and decoded fields.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   imem_req/imem_addr                - fetch request and word address
//   imem_ack/imem_rdata               - fetch completion and instruction word
//   stall, flush                      - hazard unit controls for IF/ID
//   redirect_valid/redirect_pc        - taken branch/jump target
//   id_valid/id_instr/id_pc4          - IF/ID contents
//   id_opcode..id_funct, id_imm16, id_target - decoded instruction fields
//   stall_cycles                      - saturating stall counter, only when
//                                       FETCH_STALL_CNT_EN is defined
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic [25:0] id_target
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  drop_addr_r, drop_addr_nxt_s;
  logic [31:0]  hold_buf_r, hold_buf_nxt_s;
  logic         ack_s;
  logic         load_s;
  logic [31:0]  load_instr_s;
  logic [31:0]  load_pc4_s;

  // The request is decoded from registered state; it is gated with reset so
  // the very first cycle out of reset already fetches from RESET_PC.
  assign imem_req  = ~reset & (state_r != S_HOLD);
  // In S_DROP the stale address stays on the bus until its ack, even though
  // pc_r already points at the redirect target.
  assign imem_addr = (state_r == S_DROP) ? drop_addr_r : pc_r;
  assign ack_s     = imem_req & imem_ack;
  assign load_pc4_s = pc_inc4(pc_r);

  // Next-state, PC and hold-buffer logic; redirect overrides normal flow
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    drop_addr_nxt_s = drop_addr_r;
    hold_buf_nxt_s  = hold_buf_r;
    load_s          = 1'b0;
    load_instr_s    = 32'h0000_0000;
    if (redirect_valid) begin
      pc_nxt_s = pc_align(redirect_pc);
      case (state_r)
        S_FETCH: begin
          if (ack_s) begin
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s     = S_DROP;
            drop_addr_nxt_s = pc_r;
          end
        end
        S_HOLD:  state_nxt_s = S_FETCH;
        S_DROP:  state_nxt_s = S_DROP;
        default: state_nxt_s = S_FETCH;
      endcase
    end else begin
      case (state_r)
        S_FETCH: begin
          if (ack_s) begin
            if (stall) begin
              hold_buf_nxt_s = imem_rdata;
              state_nxt_s    = S_HOLD;
            end else begin
              load_s       = 1'b1;
              load_instr_s = imem_rdata;
              pc_nxt_s     = load_pc4_s;
              state_nxt_s  = S_FETCH;
            end
          end else begin
            state_nxt_s = S_FETCH;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_s       = 1'b1;
            load_instr_s = hold_buf_r;
            pc_nxt_s     = load_pc4_s;
            state_nxt_s  = S_FETCH;
          end else begin
            state_nxt_s = S_HOLD;
          end
        end
        S_DROP: begin
          if (ack_s) begin
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_DROP;
          end
        end
        default: state_nxt_s = S_FETCH;
      endcase
    end
  end

  // Fetch FSM, PC, stale-address and hold-buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_FETCH;
      pc_r        <= pc_align(RESET_PC);
      drop_addr_r <= pc_align(RESET_PC);
      hold_buf_r  <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      drop_addr_r <= drop_addr_nxt_s;
      hold_buf_r  <= hold_buf_nxt_s;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .load      (load_s),
    .new_instr (load_instr_s),
    .new_pc4   (load_pc4_s),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc4    (id_pc4)
  );

  assign id_opcode = id_instr[OPCODE_HI:OPCODE_LO];
  assign id_rs     = id_instr[RS_HI:RS_LO];
  assign id_rt     = id_instr[RT_HI:RT_LO];
  assign id_rd     = id_instr[RD_HI:RD_LO];
  assign id_shamt  = id_instr[SHAMT_HI:SHAMT_LO];
  assign id_funct  = id_instr[FUNCT_HI:FUNCT_LO];
  assign id_imm16  = id_instr[IMM_HI:IMM_LO];
  assign id_target = id_instr[TARGET_HI:TARGET_LO];

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of stalled cycles; cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule
